// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, ALUOp codes,
// forwarding selects and the per-stage control bundle that travels down
// the ID/EX, EX/MEM and MEM/WB registers.
package pipe_ctrl_pkg;

    // RV64I major opcodes recognised by the decoder
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ADDI   = 7'b0010011;

    // ALUOp codes consumed by the ALU-control block
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Operand forwarding selects for the EX-stage muxes
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    // Controls consumed in EX
    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
    } ex_ctrl_t;

    // Controls consumed in MEM
    typedef struct packed {
        logic read;
        logic write;
        logic branch;
    } mem_ctrl_t;

    // Controls consumed in WB
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    // Full control bundle produced in ID
    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } ctrl_t;

    // A bubble does nothing in any stage
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// ID-stage main decoder: opcode -> control bundle plus which register
// sources the instruction actually reads. Unrecognised opcodes produce a
// bubble and claim no sources, so they can never stall the pipe.
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic                use_rs1,
    output logic                use_rs2
);

    // Table decode; everything defaults to zero so no X ever escapes
    always_comb begin
        ctrl    = CTRL_BUBBLE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OPCODE_W'(OP_RTYPE): begin
                ctrl.ex.alu_op    = ALUOP_FUNCT;
                ctrl.wb.reg_write = 1'b1;
                use_rs1           = 1'b1;
                use_rs2           = 1'b1;
            end
            OPCODE_W'(OP_LOAD): begin
                ctrl.ex.alu_src    = 1'b1;
                ctrl.ex.alu_op     = ALUOP_ADD;
                ctrl.mem.read      = 1'b1;
                ctrl.wb.reg_write  = 1'b1;
                ctrl.wb.mem_to_reg = 1'b1;
                use_rs1            = 1'b1;
            end
            OPCODE_W'(OP_STORE): begin
                ctrl.ex.alu_src = 1'b1;
                ctrl.ex.alu_op  = ALUOP_ADD;
                ctrl.mem.write  = 1'b1;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            OPCODE_W'(OP_BRANCH): begin
                ctrl.ex.alu_op  = ALUOP_BR;
                ctrl.mem.branch = 1'b1;
                use_rs1         = 1'b1;
                use_rs2         = 1'b1;
            end
            OPCODE_W'(OP_ADDI): begin
                ctrl.ex.alu_src   = 1'b1;
                ctrl.ex.alu_op    = ALUOP_ADD;
                ctrl.wb.reg_write = 1'b1;
                use_rs1           = 1'b1;
            end
            default: begin
                ctrl    = CTRL_BUBBLE;
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit for the 5-stage RV64I core. Owns the control/rd
// stage registers, detects RAW hazards (stall) and taken branches (flush).
// Build option PIPE_CTRL_FORWARDING_EN adds EX operand forwarding selects
// and reduces the hazard check to load-use only.
module pipe_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int OPCODE_W = 7,
    parameter int ALUOP_W  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                mem_zero,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                if_id_flush,
    output logic                pc_src,
    output logic                ex_alu_src,
    output logic [ALUOP_W-1:0]  ex_alu_op,
    output logic                mem_mem_read,
    output logic                mem_mem_write,
    output logic                mem_branch,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [REG_AW-1:0]   ex_rd,
    output logic [REG_AW-1:0]   mem_rd,
    output logic [REG_AW-1:0]   wb_rd
`ifdef PIPE_CTRL_FORWARDING_EN
    ,
    output logic [1:0]          forward_a,
    output logic [1:0]          forward_b
`endif
);

    ctrl_t     id_ctrl;
    logic      use_rs1;
    logic      use_rs2;
    ctrl_t     ex_ctrl;
    mem_ctrl_t mem_mctrl;
    wb_ctrl_t  mem_wctrl;
    wb_ctrl_t  wb_ctrl;
    logic      hazard;
    logic      stall;

    pipe_ctrl_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode  (id_opcode),
        .ctrl    (id_ctrl),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2)
    );

    // A used source that matches a writing stage's nonzero rd
    function automatic logic src_hit(input logic used,
                                     input logic [REG_AW-1:0] src,
                                     input logic wr,
                                     input logic [REG_AW-1:0] rd);
        return used && wr && (rd != '0) && (src == rd);
    endfunction

`ifdef PIPE_CTRL_FORWARDING_EN
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;

    // MEM result is younger than WB, so it wins when both match
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input logic mem_wr,
                                           input logic [REG_AW-1:0] m_rd,
                                           input logic wb_wr,
                                           input logic [REG_AW-1:0] w_rd);
        if (src_hit(1'b1, src, mem_wr, m_rd))
            return FWD_MEM;
        else if (src_hit(1'b1, src, wb_wr, w_rd))
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

    // Only a load in EX cannot be covered by forwarding
    always_comb begin
        hazard = ex_ctrl.mem.read &&
                 (src_hit(use_rs1, id_rs1, 1'b1, ex_rd) ||
                  src_hit(use_rs2, id_rs2, 1'b1, ex_rd));
    end

    // Forwarding selects for the instruction currently in EX
    always_comb begin
        forward_a = fwd_sel(ex_rs1, mem_wctrl.reg_write, mem_rd,
                            wb_ctrl.reg_write, wb_rd);
        forward_b = fwd_sel(ex_rs2, mem_wctrl.reg_write, mem_rd,
                            wb_ctrl.reg_write, wb_rd);
    end

    // Source indices follow the instruction into EX; bubbles carry none
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else if (pc_src || stall) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else begin
            ex_rs1 <= id_rs1;
            ex_rs2 <= id_rs2;
        end
    end
`else
    // Any pending write in EX or MEM blocks the reader; WB is write-through
    always_comb begin
        hazard = src_hit(use_rs1, id_rs1, ex_ctrl.wb.reg_write,   ex_rd)  ||
                 src_hit(use_rs2, id_rs2, ex_ctrl.wb.reg_write,   ex_rd)  ||
                 src_hit(use_rs1, id_rs1, mem_wctrl.reg_write,    mem_rd) ||
                 src_hit(use_rs2, id_rs2, mem_wctrl.reg_write,    mem_rd);
    end
`endif

    // Branch resolution in MEM; a taken branch overrides any stall
    always_comb begin
        pc_src      = mem_mctrl.branch & mem_zero;
        stall       = hazard & ~pc_src;
        pc_write    = ~stall;
        if_id_write = ~stall;
        if_id_flush = pc_src;
    end

    // ID/EX: bubble on stall or flush, else capture the decoded instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl <= CTRL_BUBBLE;
            ex_rd   <= '0;
        end else if (pc_src || stall) begin
            ex_ctrl <= CTRL_BUBBLE;
            ex_rd   <= '0;
        end else begin
            ex_ctrl <= id_ctrl;
            ex_rd   <= id_rd;
        end
    end

    // EX/MEM: the wrong-path instruction in EX is squashed on a taken branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_mctrl <= '0;
            mem_wctrl <= '0;
            mem_rd    <= '0;
        end else if (pc_src) begin
            mem_mctrl <= '0;
            mem_wctrl <= '0;
            mem_rd    <= '0;
        end else begin
            mem_mctrl <= ex_ctrl.mem;
            mem_wctrl <= ex_ctrl.wb;
            mem_rd    <= ex_rd;
        end
    end

    // MEM/WB: always advances; the branch itself retires harmlessly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ctrl <= '0;
            wb_rd   <= '0;
        end else begin
            wb_ctrl <= mem_wctrl;
            wb_rd   <= mem_rd;
        end
    end

    // Stage-aligned control exports
    always_comb begin
        ex_alu_src    = ex_ctrl.ex.alu_src;
        ex_alu_op     = ALUOP_W'(ex_ctrl.ex.alu_op);
        mem_mem_read  = mem_mctrl.read;
        mem_mem_write = mem_mctrl.write;
        mem_branch    = mem_mctrl.branch;
        wb_reg_write  = wb_ctrl.reg_write;
        wb_mem_to_reg = wb_ctrl.mem_to_reg;
    end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit; expectations follow the build
// option PIPE_CTRL_FORWARDING_EN when it is defined.
module tb_pipe_control_unit;

    localparam logic [6:0] R_OP  = 7'b0110011;
    localparam logic [6:0] LD_OP = 7'b0000011;
    localparam logic [6:0] SD_OP = 7'b0100011;
    localparam logic [6:0] BQ_OP = 7'b1100011;
    localparam logic [6:0] AI_OP = 7'b0010011;
    localparam logic [6:0] BAD   = 7'b1111111;
    localparam logic [6:0] NOP   = 7'b0000000;

    logic       clk;
    logic       rst_n;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       mem_zero;
    logic       pc_write, if_id_write, if_id_flush, pc_src;
    logic       ex_alu_src;
    logic [1:0] ex_alu_op;
    logic       mem_mem_read, mem_mem_write, mem_branch;
    logic       wb_reg_write, wb_mem_to_reg;
    logic [4:0] ex_rd, mem_rd, wb_rd;
`ifdef PIPE_CTRL_FORWARDING_EN
    logic [1:0] forward_a, forward_b;
`endif

    int n_chk;
    int n_fail;

    pipe_control_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_opcode     (id_opcode),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .mem_zero      (mem_zero),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .pc_src        (pc_src),
        .ex_alu_src    (ex_alu_src),
        .ex_alu_op     (ex_alu_op),
        .mem_mem_read  (mem_mem_read),
        .mem_mem_write (mem_mem_write),
        .mem_branch    (mem_branch),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .ex_rd         (ex_rd),
        .mem_rd        (mem_rd),
        .wb_rd         (wb_rd)
`ifdef PIPE_CTRL_FORWARDING_EN
        ,
        .forward_a     (forward_a),
        .forward_b     (forward_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [6:0] op, input logic [4:0] a,
                          input logic [4:0] b, input logic [4:0] d);
        id_opcode = op;
        id_rs1    = a;
        id_rs2    = b;
        id_rd     = d;
        #1;
    endtask

    task automatic drain();
        set_id(NOP, 0, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        mem_zero = 1'b0;
        set_id(NOP, 0, 0, 0);
        repeat (2) tick();

        // reset state
        check("rst_pcw",   pc_write,    1);
        check("rst_ifidw", if_id_write, 1);
        check("rst_flush", if_id_flush, 0);
        check("rst_pcsrc", pc_src,      0);
        check("rst_exop",  ex_alu_op,   0);
        check("rst_wbrw",  wb_reg_write, 0);

        // reset asserted mid-stream clears a load already in MEM
        rst_n = 1'b1;
        set_id(LD_OP, 2, 0, 5);
        tick();
        set_id(NOP, 0, 0, 0);
        tick();
        check("pre_rst_memrd", mem_mem_read, 1);
        check("pre_rst_mem_rd", mem_rd, 5);
        rst_n = 1'b0;
        #1;
        check("async_rst_memrd", mem_mem_read, 0);
        check("async_rst_mem_rd", mem_rd, 0);
        repeat (3) tick();
        check("in_rst_pcw", pc_write, 1);
        check("in_rst_ifidw", if_id_write, 1);
        check("in_rst_exsrc", ex_alu_src, 0);

        // first load after release: WB exactly 3 edges later
        rst_n = 1'b1;
        set_id(LD_OP, 2, 0, 5);
        tick();
        set_id(NOP, 0, 0, 0);
        check("ld_ex_src", ex_alu_src, 1);
        check("ld_ex_rd", ex_rd, 5);
        check("ld_wb_early1", wb_reg_write, 0);
        tick();
        check("ld_mem_read", mem_mem_read, 1);
        check("ld_wb_early2", wb_reg_write, 0);
        tick();
        check("ld_wb_rw", wb_reg_write, 1);
        check("ld_wb_m2r", wb_mem_to_reg, 1);
        check("ld_wb_rd", wb_rd, 5);
        drain();

        // load-use: ld x5 ; add x6,x5,x7
        set_id(LD_OP, 2, 0, 5);
        check("lu_pre_pcw", pc_write, 1);
        tick();
        set_id(R_OP, 5, 7, 6);
        check("lu_stall1_pcw", pc_write, 0);
        check("lu_stall1_ifidw", if_id_write, 0);
        tick();
        check("lu_bubble1_rd", ex_rd, 0);
        check("lu_bubble1_op", ex_alu_op, 0);
`ifdef PIPE_CTRL_FORWARDING_EN
        check("lu_resume_pcw", pc_write, 1);
        tick();
        check("lu_add_ex_rd", ex_rd, 6);
        check("lu_fwd_a", forward_a, 2'b01);
        check("lu_fwd_b", forward_b, 2'b00);
`else
        check("lu_stall2_pcw", pc_write, 0);
        tick();
        check("lu_bubble2_rd", ex_rd, 0);
        check("lu_resume_pcw", pc_write, 1);
        tick();
        check("lu_add_ex_rd", ex_rd, 6);
        check("lu_add_ex_op", ex_alu_op, 2'b10);
`endif
        drain();

        // ALU dependence at distance 1: add x5 ; sub x8,x9,x5
        set_id(R_OP, 1, 2, 5);
        tick();
        set_id(R_OP, 9, 5, 8);
`ifdef PIPE_CTRL_FORWARDING_EN
        check("d1_nostall", pc_write, 1);
        tick();
        check("d1_ex_rd", ex_rd, 8);
        check("d1_fwd_b", forward_b, 2'b10);
        check("d1_fwd_a", forward_a, 2'b00);
`else
        check("d1_stall1", pc_write, 0);
        tick();
        check("d1_stall2", pc_write, 0);
        tick();
        check("d1_resume", pc_write, 1);
        tick();
        check("d1_ex_rd", ex_rd, 8);
`endif
        drain();

        // addi ignores rs2; ALU dependence at distance 2
        set_id(R_OP, 1, 2, 5);
        tick();
        set_id(AI_OP, 9, 5, 6);
        check("addi_rs2_ignored", pc_write, 1);
        tick();
        set_id(R_OP, 5, 0, 7);
`ifdef PIPE_CTRL_FORWARDING_EN
        check("d2_nostall", pc_write, 1);
        tick();
        check("d2_ex_rd", ex_rd, 7);
        check("d2_fwd_a", forward_a, 2'b01);
`else
        check("d2_stall", pc_write, 0);
        tick();
        check("d2_resume", pc_write, 1);
        tick();
        check("d2_ex_rd", ex_rd, 7);
`endif
        drain();

        // taken beq in MEM while a load-use hazard sits in ID
        set_id(BQ_OP, 1, 2, 0);
        tick();
        set_id(LD_OP, 3, 0, 5);
        tick();
        set_id(R_OP, 5, 7, 6);
        check("br_nt_pcsrc", pc_src, 0);
        check("br_nt_stall", pc_write, 0);
        mem_zero = 1'b1;
        #1;
        check("br_pcsrc", pc_src, 1);
        check("br_flush", if_id_flush, 1);
        check("br_pcw", pc_write, 1);
        check("br_ifidw", if_id_write, 1);
        tick();
        mem_zero = 1'b0;
        set_id(NOP, 0, 0, 0);
        check("br_ex_src", ex_alu_src, 0);
        check("br_ex_op", ex_alu_op, 0);
        check("br_ex_rd", ex_rd, 0);
        check("br_mem_read", mem_mem_read, 0);
        check("br_mem_branch", mem_branch, 0);
        check("br_mem_rd", mem_rd, 0);
        check("br_after_pcsrc", pc_src, 0);
        drain();

        // x0 never hazards; illegal opcode carries zero controls
        set_id(AI_OP, 0, 0, 0);
        tick();
        set_id(R_OP, 0, 0, 1);
        check("x0_nostall", pc_write, 1);
        tick();
`ifdef PIPE_CTRL_FORWARDING_EN
        check("x0_fwd_a", forward_a, 2'b00);
        check("x0_fwd_b", forward_b, 2'b00);
`endif
        set_id(BAD, 1, 1, 4);
        check("bad_nostall", pc_write, 1);
        tick();
        set_id(NOP, 0, 0, 0);
        check("bad_ex_src", ex_alu_src, 0);
        check("bad_ex_op", ex_alu_op, 0);
        tick();
        check("bad_mem_rd", mem_mem_read, 0);
        check("bad_mem_wr", mem_mem_write, 0);
        check("bad_mem_br", mem_branch, 0);
        tick();
        check("bad_wb_rw", wb_reg_write, 0);
        check("bad_wb_m2r", wb_mem_to_reg, 0);
        drain();

        // sd x5 after add x5 at distance 3: WB match is ignored
        set_id(R_OP, 1, 2, 5);
        tick();
        set_id(NOP, 0, 0, 0);
        tick();
        tick();
        set_id(SD_OP, 2, 5, 0);
        check("sd_wb_rw", wb_reg_write, 1);
        check("sd_wb_rd", wb_rd, 5);
        check("sd_nostall", pc_write, 1);
        tick();
        set_id(NOP, 0, 0, 0);
        check("sd_ex_src", ex_alu_src, 1);
        check("sd_ex_op", ex_alu_op, 0);
        tick();
        check("sd_mem_wr", mem_mem_write, 1);
        check("sd_mem_rd", mem_mem_read, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
